// File: rtl/hdmi_tx_config_seq.sv
// hdmi_tx_config_seq
//   Brings up an ADV7513 HDMI transmitter. After a power-up delay it walks an
//   internal register table and issues one I2C write per entry to a byte-level
//   I2C master. NACKed writes are retried up to RETRY_MAX extra times. The
//   outcome is reported on cfg_done / cfg_error.
//
//   Optional build macro HDMI_CFG_HPD_REINIT_EN: once the sequence has finished
//   (done or error), a debounced hot-plug on hdmi_tx_int replays the table from
//   index 0 without the power-up wait. Without the macro, hdmi_tx_int is unused
//   and only rst leaves DONE/ERROR.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   hdmi_tx_int    transmitter interrupt / hot-plug (already synchronised)
//   i2c_cmd_valid  write command pending (held until accepted)
//   i2c_cmd_ready  master accepts the command this cycle
//   i2c_cmd_data   {DEV_ADDR, reg, val}; zero while no command is pending
//   i2c_rsp_valid  one-cycle pulse, transaction finished
//   i2c_rsp_nack   qualified by i2c_rsp_valid, 1 = NACK
//   cfg_done       every entry written (sticky)
//   cfg_error      an entry ran out of retries (sticky)
//   cfg_index      current entry, or the failing entry after an error
//
// state   | meaning
// PWRUP   | power-up wait after reset
// ISSUE   | command presented, waiting for ready
// WAIT    | command accepted, waiting for the response pulse
// NEXT    | entry acknowledged, advance or finish
// DONE    | all entries written
// ERROR   | entry at cfg_index failed on every attempt
module hdmi_tx_config_seq #(
  parameter logic [6:0] DEV_ADDR     = 7'h39,
  parameter int         NUM_REGS     = 31,
  parameter int         RETRY_MAX    = 3,
  parameter int         PWRUP_CYCLES = 1_000_000,
  parameter int         HPD_DEBOUNCE = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdmi_tx_int,
  output logic        i2c_cmd_valid,
  input  logic        i2c_cmd_ready,
  output logic [22:0] i2c_cmd_data,
  input  logic        i2c_rsp_valid,
  input  logic        i2c_rsp_nack,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [7:0]  cfg_index
);

  localparam int PW = (PWRUP_CYCLES < 1) ? 1 : $clog2(PWRUP_CYCLES + 1);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [PW-1:0] PWRUP_TC = PW'(PWRUP_CYCLES);
  localparam logic [RW-1:0] RETRY_TC = RW'(RETRY_MAX);
  localparam logic [7:0]    LAST_IDX = 8'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_ISSUE, S_WAIT, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   wait_cnt, wait_cnt_nx;
  logic [RW-1:0]   retry_cnt, retry_cnt_nx;
  logic [7:0]      index_nx;
  logic [15:0]     table_entry;
  logic            hpd_fire;

  // Register table: {reg, val}
  always_comb begin
    case (cfg_index)
      8'd0:    table_entry = 16'h4110;  // power up the transmitter
      8'd1:    table_entry = 16'h9803;  // fixed register required by the part
      default: table_entry = 16'h0000;
    endcase
  end

  always_comb begin
    state_nx      = state;
    wait_cnt_nx   = wait_cnt;
    retry_cnt_nx  = retry_cnt;
    index_nx      = cfg_index;
    i2c_cmd_valid = 1'b0;
    case (state)
      S_PWRUP: begin
        // Leaves after PWRUP_CYCLES+1 cycles so that the first command is
        // visible exactly PWRUP_CYCLES+1 cycles after reset is released.
        if (wait_cnt == PWRUP_TC) state_nx = S_ISSUE;
        else                      wait_cnt_nx = wait_cnt + PW'(1);
      end
      S_ISSUE: begin
        i2c_cmd_valid = 1'b1;
        if (i2c_cmd_ready) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (i2c_rsp_valid) begin
          if (!i2c_rsp_nack) begin
            state_nx = S_NEXT;
          end else if (retry_cnt < RETRY_TC) begin
            retry_cnt_nx = retry_cnt + RW'(1);
            state_nx     = S_ISSUE;
          end else begin
            state_nx = S_ERROR;
          end
        end
      end
      S_NEXT: begin
        retry_cnt_nx = '0;
        if (cfg_index == LAST_IDX) begin
          state_nx = S_DONE;
        end else begin
          index_nx = cfg_index + 8'd1;
          state_nx = S_ISSUE;
        end
      end
      S_DONE, S_ERROR: begin
        if (hpd_fire) begin
          index_nx     = 8'd0;
          retry_cnt_nx = '0;
          state_nx     = S_ISSUE;
        end
      end
      default: state_nx = S_PWRUP;
    endcase
  end

  assign i2c_cmd_data = i2c_cmd_valid ? {DEV_ADDR, table_entry} : 23'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_PWRUP;
      wait_cnt  <= '0;
      retry_cnt <= '0;
      cfg_index <= 8'd0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_cnt_nx;
      retry_cnt <= retry_cnt_nx;
      cfg_index <= index_nx;
      // Status flags trail the state by one cycle; a hot-plug replay clears
      // them on the same edge that leaves DONE/ERROR.
      cfg_done  <= (state == S_DONE)  && !hpd_fire;
      cfg_error <= (state == S_ERROR) && !hpd_fire;
    end
  end

`ifdef HDMI_CFG_HPD_REINIT_EN
  localparam int HW = (HPD_DEBOUNCE < 1) ? 1 : $clog2(HPD_DEBOUNCE + 1);
  localparam logic [HW-1:0] HPD_TC = HW'(HPD_DEBOUNCE - 1);

  logic [HW-1:0] hpd_cnt;
  logic          hpd_armed;
  logic          in_final;

  assign in_final = (state == S_DONE) || (state == S_ERROR);
  assign hpd_fire = in_final && hdmi_tx_int && hpd_armed && (hpd_cnt == HPD_TC);

  // hpd_armed forces hdmi_tx_int to drop before another replay can start.
  always_ff @(posedge clk) begin
    if (rst) begin
      hpd_cnt   <= '0;
      hpd_armed <= 1'b1;
    end else if (!hdmi_tx_int) begin
      hpd_cnt   <= '0;
      hpd_armed <= 1'b1;
    end else if (hpd_fire) begin
      hpd_cnt   <= '0;
      hpd_armed <= 1'b0;
    end else if (in_final && hpd_armed) begin
      hpd_cnt <= hpd_cnt + HW'(1);
    end else begin
      hpd_cnt <= '0;
    end
  end
`else
  localparam int unused_hpd_debounce = HPD_DEBOUNCE;
  logic unused_hpd_int;
  assign unused_hpd_int = hdmi_tx_int;
  assign hpd_fire       = 1'b0;
`endif

endmodule
